// File: rtl/simd_pkg.sv
// Shared constants and helpers for the ALU issue stage: widths, opcodes,
// instruction field layout and small decode functions.
package simd_pkg;

    localparam int DATA_W  = 16;
    localparam int NREG    = 8;
    localparam int REG_AW  = 3;
    localparam int INSTR_W = 16;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h1,
        OP_SUB    = 4'h2,
        OP_BITREV = 4'h3,
        OP_MUL    = 4'h4
    } opcode_e;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPC_LSB +: 4];
        f.rd     = instr[RD_LSB  +: REG_AW];
        f.rs1    = instr[RS1_LSB +: REG_AW];
        f.rs2    = instr[RS2_LSB +: REG_AW];
        return f;
    endfunction

    function automatic logic is_legal(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_BITREV) || (opc == OP_MUL);
    endfunction

    // bitrev is the only unary op, so it is the only one that ignores rs2
    function automatic logic uses_rs2(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL);
    endfunction

    // Bit order: [0] add, [1] sub, [2] bitrev, [3] mul
    function automatic logic [3:0] op_onehot(input logic [3:0] opc);
        logic [3:0] oh;
        case (opc)
            OP_ADD:    oh = 4'b0001;
            OP_SUB:    oh = 4'b0010;
            OP_BITREV: oh = 4'b0100;
            OP_MUL:    oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file with per-register busy scoreboard; two bypassed read ports,
// one write port, and hazard flags that already account for same-cycle writeback.
module alu_regfile
    import simd_pkg::*;
#(
    parameter int DATA_W = simd_pkg::DATA_W,
    parameter int NREG   = simd_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_hazard,
    output logic              rs2_hazard,
    output logic              rd_hazard
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    // Set is applied after clear so a same-register collision leaves it busy
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs1_data   = (wb_en && wb_addr == rs1_addr) ? wb_data : regs_q[rs1_addr];
        rs2_data   = (wb_en && wb_addr == rs2_addr) ? wb_data : regs_q[rs2_addr];
        rs1_hazard = busy_q[rs1_addr] && !(wb_en && wb_addr == rs1_addr);
        rs2_hazard = busy_q[rs2_addr] && !(wb_en && wb_addr == rs2_addr);
        rd_hazard  = busy_q[rd_addr]  && !(wb_en && wb_addr == rd_addr);
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction, checks the scoreboard, and hands a
// registered one-hot operation plus operands to the ALU under valid/ready.
module alu_issue
    import simd_pkg::*;
#(
    parameter int DATA_W = simd_pkg::DATA_W,
    parameter int NREG   = simd_pkg::NREG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               Radd_en,
    output logic               Rsub_en,
    output logic               bitrev_en,
    output logic               mul_en,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rs2_data,
    output logic [REG_AW-1:0]  rd_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               illegal_op
);

    instr_fields_t     fields;
    logic              legal;
    logic              hazard;
    logic              accept;
    logic              drop;
    logic              unused_bits;

    logic [DATA_W-1:0] rf_rs1_data;
    logic [DATA_W-1:0] rf_rs2_data;
    logic              rs1_hazard;
    logic              rs2_hazard;
    logic              rd_hazard;

    logic              out_valid_q,  out_valid_d;
    logic [3:0]        en_q,         en_d;
    logic [DATA_W-1:0] rs1_data_q,   rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,   rs2_data_d;
    logic [REG_AW-1:0] rd_out_q,     rd_out_d;
    logic              illegal_op_q, illegal_op_d;

    assign unused_bits = ^instr[RS2_LSB-1:0];

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .set_en     (accept),
        .set_addr   (fields.rd),
        .rs1_addr   (fields.rs1),
        .rs2_addr   (fields.rs2),
        .rd_addr    (fields.rd),
        .rs1_data   (rf_rs1_data),
        .rs2_data   (rf_rs2_data),
        .rs1_hazard (rs1_hazard),
        .rs2_hazard (rs2_hazard),
        .rd_hazard  (rd_hazard)
    );

    // Illegal opcodes are always consumed, even while the output is stalled
    always_comb begin
        fields       = split_instr(instr);
        legal        = is_legal(fields.opcode);
        hazard       = rs1_hazard || rd_hazard || (uses_rs2(fields.opcode) && rs2_hazard);
        instr_ready  = rst && (legal ? ((!out_valid_q || out_ready) && !hazard) : 1'b1);
        accept       = instr_valid && instr_ready && legal;
        drop         = instr_valid && instr_ready && !legal;

        out_valid_d  = out_valid_q;
        en_d         = en_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        rd_out_d     = rd_out_q;
        illegal_op_d = drop;

        if (accept) begin
            out_valid_d = 1'b1;
            en_d        = op_onehot(fields.opcode);
            rs1_data_d  = rf_rs1_data;
            rs2_data_d  = rf_rs2_data;
            rd_out_d    = fields.rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            en_d        = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            en_q         <= 4'b0000;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            rd_out_q     <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            en_q         <= en_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            rd_out_q     <= rd_out_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign Radd_en    = en_q[0];
    assign Rsub_en    = en_q[1];
    assign bitrev_en  = en_q[2];
    assign mul_en     = en_q[3];
    assign rs1_data   = rs1_data_q;
    assign rs2_data   = rs2_data_q;
    assign rd_out     = rd_out_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and random stimulus for alu_issue, checked against a behavioural
// model of the register file, scoreboard and output register.
module tb_alu_issue;
    import simd_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic          instr_ready;
    logic          wb_en = 1'b0;
    logic [2:0]    wb_addr = '0;
    logic [W-1:0]  wb_data = '0;
    logic          Radd_en, Rsub_en, bitrev_en, mul_en;
    logic [W-1:0]  rs1_data, rs2_data;
    logic [2:0]    rd_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          illegal_op;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_rdy;

    logic [W-1:0] m_rf [8];
    bit           m_busy [8];
    bit           m_valid;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic [2:0]   m_rd;
    bit           m_ill;

    always #5 clk = ~clk;

    alu_issue #(.DATA_W(W), .NREG(8)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .Radd_en(Radd_en), .Rsub_en(Rsub_en), .bitrev_en(bitrev_en), .mul_en(mul_en),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_out(rd_out),
        .out_valid(out_valid), .out_ready(out_ready), .illegal_op(illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic bit m_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic bit m_blocked(input logic [2:0] r, input bit wbe, input logic [2:0] wba);
        return m_busy[r] && !(wbe && wba == r);
    endfunction

    function automatic bit model_ready(input logic [15:0] ins, input bit wbe,
                                       input logic [2:0] wba, input bit ordy);
        logic [3:0] op;
        bit haz;
        op = ins[15:12];
        if (!rst) return 1'b0;
        if (!m_legal(op)) return 1'b1;
        haz = m_blocked(ins[8:6], wbe, wba) || m_blocked(ins[11:9], wbe, wba) ||
              ((op != 4'd3) && m_blocked(ins[5:3], wbe, wba));
        return (!m_valid || ordy) && !haz;
    endfunction

    task automatic model_edge(input bit v, input logic [15:0] ins, input bit wbe,
                              input logic [2:0] wba, input logic [W-1:0] wbd,
                              input bit ordy, input bit rdy);
        logic [W-1:0] a, b;
        bit acc, drp;
        if (!rst) begin
            foreach (m_rf[i]) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
            m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_ill = 0;
        end else begin
            acc = v && rdy && m_legal(ins[15:12]);
            drp = v && rdy && !m_legal(ins[15:12]);
            a = (wbe && wba == ins[8:6]) ? wbd : m_rf[ins[8:6]];
            b = (wbe && wba == ins[5:3]) ? wbd : m_rf[ins[5:3]];
            if (wbe) begin
                m_rf[wba]   = wbd;
                m_busy[wba] = 1'b0;
            end
            if (acc) begin
                m_busy[ins[11:9]] = 1'b1;
                m_valid = 1'b1;
                m_op    = ins[15:12];
                m_a     = a;
                m_b     = b;
                m_rd    = ins[11:9];
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            m_ill = drp;
        end
    endtask

    task automatic checkOutput();
        check("out_valid",  out_valid,  m_valid);
        check("Radd_en",    Radd_en,    m_valid && m_op == 4'd1);
        check("Rsub_en",    Rsub_en,    m_valid && m_op == 4'd2);
        check("bitrev_en",  bitrev_en,  m_valid && m_op == 4'd3);
        check("mul_en",     mul_en,     m_valid && m_op == 4'd4);
        check("rs1_data",   rs1_data,   m_a);
        check("rs2_data",   rs2_data,   m_b);
        check("rd_out",     rd_out,     m_rd);
        check("illegal_op", illegal_op, m_ill);
    endtask

    task automatic applyStimulus(input bit v, input logic [15:0] ins, input bit wbe,
                                 input logic [2:0] wba, input logic [W-1:0] wbd, input bit ordy);
        bit exp_rdy;
        instr_valid = v;
        instr       = ins;
        wb_en       = wbe;
        wb_addr     = wba;
        wb_data     = wbd;
        out_ready   = ordy;
        #1;
        exp_rdy  = model_ready(ins, wbe, wba, ordy);
        last_rdy = instr_ready;
        check("instr_ready", instr_ready, exp_rdy);
        @(posedge clk);
        model_edge(v, ins, wbe, wba, wbd, ordy, exp_rdy);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] op;
        int pick;

        rst = 1'b0;
        applyStimulus(0, 16'h0, 1, 3'd1, 16'hdead, 1);
        applyStimulus(0, 16'h0, 1, 3'd2, 16'hbeef, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_ready", last_rdy, 0);
        rst = 1'b1;

        applyStimulus(0, 16'h0, 1, 3'd1, 16'h0005, 1);
        applyStimulus(0, 16'h0, 1, 3'd2, 16'h0003, 1);
        applyStimulus(1, mk(OP_ADD, 3, 1, 2), 0, 0, 0, 1);
        check("add_en", Radd_en, 1);
        check("add_rs1", rs1_data, 16'h0005);
        check("add_rs2", rs2_data, 16'h0003);
        check("add_rd", rd_out, 3);

        applyStimulus(1, mk(OP_SUB, 4, 3, 2), 0, 0, 0, 1);
        check("raw_stall", last_rdy, 0);
        applyStimulus(1, mk(OP_SUB, 4, 3, 2), 1, 3'd3, 16'h0008, 1);
        check("wb_release", last_rdy, 1);
        check("bypass_rs1", rs1_data, 16'h0008);
        check("sub_en", Rsub_en, 1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, mk(OP_ADD, 5, 1, 2), 0, 0, 0, 0);
            check("stall_ready", last_rdy, 0);
            check("stall_hold_rs1", rs1_data, 16'h0008);
        end
        applyStimulus(1, mk(OP_ADD, 5, 1, 2), 0, 0, 0, 1);
        check("stall_release", last_rdy, 1);
        applyStimulus(1, mk(OP_MUL, 6, 1, 2), 0, 0, 0, 1);
        check("back_to_back", last_rdy, 1);
        check("mul_en", mul_en, 1);
        check("mul_rd", rd_out, 6);

        applyStimulus(1, mk(4'hF, 7, 0, 0), 0, 0, 0, 0);
        check("illegal_ready", last_rdy, 1);
        check("illegal_pulse", illegal_op, 1);
        check("illegal_keep_valid", out_valid, 1);
        applyStimulus(0, 16'h0, 0, 0, 0, 1);
        check("illegal_one_shot", illegal_op, 0);
        applyStimulus(1, mk(OP_ADD, 7, 7, 7), 0, 0, 0, 1);
        check("illegal_no_busy", last_rdy, 1);

        applyStimulus(1, mk(OP_ADD, 2, 1, 1), 0, 0, 0, 1);
        applyStimulus(0, 16'h0, 1, 3'd4, 16'h1234, 1);
        applyStimulus(1, mk(OP_BITREV, 0, 4, 2), 0, 0, 0, 1);
        check("bitrev_no_rs2", last_rdy, 1);
        check("bitrev_en", bitrev_en, 1);

        applyStimulus(1, mk(OP_ADD, 1, 0, 0), 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1, mk(OP_ADD, 1, 0, 0), 1, 3'd3, 16'hbeef, 0);
        check("midreset_valid", out_valid, 0);
        rst = 1'b1;
        applyStimulus(1, mk(OP_ADD, 3, 2, 0), 0, 0, 0, 1);
        check("busy_cleared", last_rdy, 1);
        check("rf_zero_rs1", rs1_data, 0);
        check("rf_zero_rs2", rs2_data, 0);

        for (int i = 0; i < 400; i++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 8)       op = 4'(pick % 4 + 1);
            else if (pick == 8) op = 4'h0;
            else                op = 4'($urandom_range(5, 15));
            rst = ($urandom_range(0, 99) != 0);
            applyStimulus($urandom_range(0, 3) != 0,
                          mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                             3'($urandom_range(0, 7))),
                          $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                          16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
